fp_align_stage: RTL

FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

---
 rtl/fp_align_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fp_align_stage.sv
// Two-stage single-precision operand aligner: S1 orders the operands by magnitude,
// S2 right-shifts the smaller mantissa with guard/round/sticky for the adder.
module fp_align_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        big_sign,
  output logic        eff_sub,
  output logic [7:0]  big_exp,
  output logic [23:0] big_mant,
  output logic [26:0] small_mant
);

  // Stage enables: a stage loads when its successor is empty or draining.
  logic s1_vld_q, s2_vld_q;
  logic s1_en, s2_en;

  assign s2_en    = !s2_vld_q || out_ready;
  assign s1_en    = !s1_vld_q || s2_en;
  assign in_ready = s1_en;

  // ---------------- S1: compare / swap ----------------
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [8:0]  d_ab, d_ba;
  logic        a_big;

  logic        s1_sign_d, s1_eff_d;
  logic [7:0]  s1_exp_d, s1_diff_d;
  logic [23:0] s1_bm_d, s1_sm_d;

  logic        s1_sign_q, s1_eff_q;
  logic [7:0]  s1_exp_q, s1_diff_q;
  logic [23:0] s1_bm_q, s1_sm_q;

  always_comb begin
    // Denormals/zero carry no hidden bit but sit at exponent 1.
    ea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma   = {|a[30:23], a[22:0]};
    mb   = {|b[30:23], b[22:0]};
    d_ab = {1'b0, ea} + {1'b0, ~eb} + 9'd1;
    d_ba = {1'b0, eb} + {1'b0, ~ea} + 9'd1;
    // Carry out with a nonzero difference means ea > eb; ties fall to the mantissa.
    a_big = (d_ab[8] && (d_ab[7:0] != 8'd0)) || ((ea == eb) && (ma >= mb));

    s1_sign_d = a_big ? a[31]    : b[31];
    s1_eff_d  = a[31] ^ b[31];
    s1_exp_d  = a_big ? a[30:23] : b[30:23];
    s1_bm_d   = a_big ? ma       : mb;
    s1_sm_d   = a_big ? mb       : ma;
    s1_diff_d = a_big ? d_ab[7:0] : d_ba[7:0];
  end

  // ---------------- S2: align shift ----------------
  logic [26:0] ext, shifted, lost, s2_sm_d;

  always_comb begin
    ext     = {s1_sm_q, 3'b000};
    shifted = ext >> s1_diff_q;
    lost    = ext & ~(27'h7FF_FFFF << s1_diff_q);
    if (s1_diff_q >= 8'd27)
      s2_sm_d = {26'd0, |s1_sm_q};
    else
      s2_sm_d = shifted | {26'd0, |lost};
  end

  logic        s2_sign_q, s2_eff_q;
  logic [7:0]  s2_exp_q;
  logic [23:0] s2_bm_q;
  logic [26:0] s2_sm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      if (s1_en) s1_vld_q <= in_valid;
      if (s2_en) s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign_q <= 1'b0;
      s1_eff_q  <= 1'b0;
      s1_exp_q  <= 8'd0;
      s1_diff_q <= 8'd0;
      s1_bm_q   <= 24'd0;
      s1_sm_q   <= 24'd0;
      s2_sign_q <= 1'b0;
      s2_eff_q  <= 1'b0;
      s2_exp_q  <= 8'd0;
      s2_bm_q   <= 24'd0;
      s2_sm_q   <= 27'd0;
    end else begin
      if (s1_en && in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_eff_q  <= s1_eff_d;
        s1_exp_q  <= s1_exp_d;
        s1_diff_q <= s1_diff_d;
        s1_bm_q   <= s1_bm_d;
        s1_sm_q   <= s1_sm_d;
      end
      if (s2_en && s1_vld_q) begin
        s2_sign_q <= s1_sign_q;
        s2_eff_q  <= s1_eff_q;
        s2_exp_q  <= s1_exp_q;
        s2_bm_q   <= s1_bm_q;
        s2_sm_q   <= s2_sm_d;
      end
    end
  end

  assign out_valid  = s2_vld_q;
  assign big_sign   = s2_sign_q;
  assign eff_sub    = s2_eff_q;
  assign big_exp    = s2_exp_q;
  assign big_mant   = s2_bm_q;
  assign small_mant = s2_sm_q;

endmodule
